// File: rtl/regbank_wr_arbiter_pkg.sv
// Shared encodings and default widths for the register-bank write arbiter.
package regbank_wr_arbiter_pkg;
    localparam int W_DEF  = 6;
    localparam int AW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;
endpackage

// File: rtl/regbank_wr_arbiter_if.sv
// Requester/read-port bundle between the two writers, the operand path and the arbiter.
interface regbank_wr_arbiter_if
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF
);
    logic          Req0;
    logic [AW-1:0] Addr0;
    logic [W-1:0]  Data0;
    logic          Ack0;
    logic          Req1;
    logic [AW-1:0] Addr1;
    logic [W-1:0]  Data1;
    logic          Ack1;
    logic [AW-1:0] RAddr;
    logic [W-1:0]  RData;
    logic          Busy;

    modport master (
        output Req0, Addr0, Data0, Req1, Addr1, Data1, RAddr,
        input  Ack0, Ack1, RData, Busy
    );

    modport slave (
        input  Req0, Addr0, Data0, Req1, Addr1, Data1, RAddr,
        output Ack0, Ack1, RData, Busy
    );
endinterface

// File: rtl/regbank_wr_arbiter_wr_reg6.sv
// W-bit storage register with load enable; clear wins over load.
module wr_reg6 #(
    parameter int W = 6
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge Clk) begin
        if (Clr)       q_q <= '0;
        else if (ld_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin two-requester write arbiter in front of a four-entry register bank.
module regbank_wr_arbiter
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF
) (
    input logic                 Clk,
    input logic                 Clr,
    regbank_wr_arbiter_if.slave bus
);
    localparam int NREG = 1 << AW;

    state_e                   state_q, state_d;
    logic                     pri_q, pri_d;
    logic [AW-1:0]            haddr_q, haddr_d;
    logic [W-1:0]             hdata_q, hdata_d;
    logic                     req0_v, req1_v, wr_act;
    logic [NREG-1:0]          en;
    logic [NREG-1:0][W-1:0]   reg_q;

    // A requester just granted is masked for one decision: its Req may still be up.
    assign req0_v = bus.Req0 && (state_q != GNT0);
    assign req1_v = bus.Req1 && (state_q != GNT1);

    always_comb begin
        state_d = IDLE;
        pri_d   = pri_q;
        haddr_d = haddr_q;
        hdata_d = hdata_q;
        if (req0_v && (!req1_v || !pri_q)) state_d = GNT0;
        else if (req1_v)                   state_d = GNT1;
        case (state_d)
            GNT0: begin
                pri_d   = 1'b1;
                haddr_d = bus.Addr0;
                hdata_d = bus.Data0;
            end
            GNT1: begin
                pri_d   = 1'b0;
                haddr_d = bus.Addr1;
                hdata_d = bus.Data1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            haddr_q <= '0;
            hdata_q <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            haddr_q <= haddr_d;
            hdata_q <= hdata_d;
        end
    end

    // Clr kills acks and enables immediately so an aborted grant leaves no trace.
    assign wr_act = (state_q != IDLE) && !Clr;

    always_comb begin
        en = '0;
        for (int i = 0; i < NREG; i++)
            en[i] = wr_act && (haddr_q == AW'(i));
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        wr_reg6 #(.W(W)) u_reg (
            .Clk  (Clk),
            .Clr  (Clr),
            .ld_i (en[g]),
            .d_i  (hdata_q),
            .q_o  (reg_q[g])
        );
    end

    assign bus.Ack0  = (state_q == GNT0) && !Clr;
    assign bus.Ack1  = (state_q == GNT1) && !Clr;
    assign bus.Busy  = (state_q != IDLE);
    assign bus.RData = reg_q[bus.RAddr];
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for the register-bank write arbiter; each task checks its own scenario.
module tb_regbank_wr_arbiter;
    logic Clk = 1'b0;
    logic Clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regbank_wr_arbiter_if #(.W(6), .AW(2)) bus ();

    regbank_wr_arbiter #(.W(6), .AW(2)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Clr = 1'b1;
        tick();
        tick();
        Clr = 1'b0;
    endtask

    task automatic test_reset();
        bus.Req0 = 0; bus.Addr0 = 0; bus.Data0 = 0;
        bus.Req1 = 0; bus.Addr1 = 0; bus.Data1 = 0;
        bus.RAddr = 0;
        do_reset();
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        checks++; if (bus.Ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", bus.Ack0); end
        checks++; if (bus.Ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got %b want 0", bus.Ack1); end
        for (int a = 0; a < 4; a++) begin
            bus.RAddr = 2'(a);
            #1;
            checks++;
            if (bus.RData !== 6'h00) begin errors++; $display("FAIL reset_rdata[%0d] got %h want 00", a, bus.RData); end
        end
    endtask

    task automatic test_single_write();
        bus.Req0 = 1; bus.Addr0 = 2; bus.Data0 = 6'h2A; bus.RAddr = 2;
        #1;
        checks++; if (bus.Ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_n got %b want 0", bus.Ack0); end
        tick();
        checks++; if (bus.Ack0 !== 1'b1) begin errors++; $display("FAIL single_ack_n1 got %b want 1", bus.Ack0); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL single_busy_n1 got %b want 1", bus.Busy); end
        checks++; if (bus.RData !== 6'h00) begin errors++; $display("FAIL single_old_data got %h want 00", bus.RData); end
        bus.Req0 = 0;
        tick();
        checks++; if (bus.Ack0 !== 1'b0) begin errors++; $display("FAIL single_ack_n2 got %b want 0", bus.Ack0); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_busy_n2 got %b want 0", bus.Busy); end
        checks++; if (bus.RData !== 6'h2A) begin errors++; $display("FAIL single_rdata got %h want 2a", bus.RData); end
    endtask

    task automatic test_contention();
        do_reset();
        bus.Req0 = 1; bus.Addr0 = 1; bus.Data0 = 6'h11;
        bus.Req1 = 1; bus.Addr1 = 3; bus.Data1 = 6'h33;
        tick();
        checks++; if ({bus.Ack0, bus.Ack1} !== 2'b10) begin errors++; $display("FAIL cont_n1 acks got %b want 10", {bus.Ack0, bus.Ack1}); end
        bus.Req0 = 0;
        tick();
        checks++; if ({bus.Ack0, bus.Ack1} !== 2'b01) begin errors++; $display("FAIL cont_n2 acks got %b want 01", {bus.Ack0, bus.Ack1}); end
        bus.Req1 = 0;
        tick();
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL cont_idle busy got %b want 0", bus.Busy); end
        bus.RAddr = 1; #1;
        checks++; if (bus.RData !== 6'h11) begin errors++; $display("FAIL cont_reg1 got %h want 11", bus.RData); end
        bus.RAddr = 3; #1;
        checks++; if (bus.RData !== 6'h33) begin errors++; $display("FAIL cont_reg3 got %h want 33", bus.RData); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ack [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [5:0] exp_rd  [5] = '{6'h00, 6'h01, 6'h3E, 6'h02, 6'h3F};
        int n0 = 0;
        int n1 = 0;
        do_reset();
        bus.RAddr = 0;
        bus.Req0 = 1; bus.Addr0 = 0; bus.Data0 = 6'h01;
        bus.Req1 = 1; bus.Addr1 = 0; bus.Data1 = 6'h3E;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 4) begin
                checks++;
                if ({bus.Ack0, bus.Ack1} !== exp_ack[c]) begin
                    errors++; $display("FAIL b2b_ack[%0d] got %b want %b", c, {bus.Ack0, bus.Ack1}, exp_ack[c]);
                end
            end
            checks++;
            if (bus.RData !== exp_rd[c]) begin
                errors++; $display("FAIL b2b_reg0[%0d] got %h want %h", c, bus.RData, exp_rd[c]);
            end
            if (bus.Ack0) begin n0++; if (n0 == 1) bus.Data0 = 6'h02; else bus.Req0 = 0; end
            if (bus.Ack1) begin n1++; if (n1 == 1) bus.Data1 = 6'h3F; else bus.Req1 = 0; end
        end
        bus.Req0 = 0; bus.Req1 = 0;
    endtask

    task automatic test_reset_mid_grant();
        bus.Req1 = 1; bus.Addr1 = 1; bus.Data1 = 6'h15; bus.RAddr = 1;
        tick();
        checks++; if (bus.Ack1 !== 1'b1) begin errors++; $display("FAIL midrst_pre_ack1 got %b want 1", bus.Ack1); end
        Clr = 1; bus.Req1 = 0;
        #1;
        checks++; if (bus.Ack1 !== 1'b0) begin errors++; $display("FAIL midrst_ack1 got %b want 0", bus.Ack1); end
        tick();
        Clr = 0;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.Busy); end
        checks++; if (bus.RData !== 6'h00) begin errors++; $display("FAIL midrst_reg1 got %h want 00", bus.RData); end
        tick();
        checks++; if (bus.Ack1 !== 1'b0) begin errors++; $display("FAIL midrst_after_ack1 got %b want 0", bus.Ack1); end
    endtask

    task automatic test_masking();
        logic prev = 1'b0;
        int   acks = 0;
        bus.RAddr = 0;
        bus.Req0 = 1; bus.Addr0 = 0; bus.Data0 = 6'h05;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (bus.Ack0 !== ((c % 2) == 0)) begin
                errors++; $display("FAIL mask_ack[%0d] got %b want %b", c, bus.Ack0, ((c % 2) == 0));
            end
            checks++;
            if (prev && bus.Ack0) begin errors++; $display("FAIL mask_consecutive[%0d] got 11 want not 11", c); end
            prev = bus.Ack0;
            if (bus.Ack0 === 1'b1) acks++;
        end
        bus.Req0 = 0;
        checks++; if (acks != 4) begin errors++; $display("FAIL mask_count got %0d want 4", acks); end
        tick();
        tick();
        checks++; if (bus.RData !== 6'h05) begin errors++; $display("FAIL mask_reg0 got %h want 05", bus.RData); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_grant();
        test_masking();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
